// File: rtl/sc_speedcomparator_pkg.sv
// ----------------------------------------------------------------------------
// sc_speedcomparator_pkg
// Shared definitions for the speed comparator block:
//   - FSM state encoding (WAIT=0, TICK=1)
//   - speed level width
//   - default per-level tick thresholds (level 0 = slowest)
// ----------------------------------------------------------------------------
package sc_speedcomparator_pkg;

    typedef enum logic [0:0] {
        SC_WAIT = 1'b0,
        SC_TICK = 1'b1
    } sc_state_e;

    localparam int SC_LEVEL_W = 2;

    localparam int unsigned SC_LEVEL0_DEFAULT = 32'd50000000;
    localparam int unsigned SC_LEVEL1_DEFAULT = 32'd25000000;
    localparam int unsigned SC_LEVEL2_DEFAULT = 32'd12500000;
    localparam int unsigned SC_LEVEL3_DEFAULT = 32'd6250000;

endpackage

// File: rtl/sc_speedcomparator_edgedetect.sv
// ----------------------------------------------------------------------------
// sc_edgedetect
// Falling-edge detector for an active-low level input. The history flop
// resets to 1 (input idle high), so an idle input never produces a pulse.
// A held-low input produces exactly one pulse.
//
// Ports:
//   clk_i   in   clock, rising edge
//   rst_ni  in   asynchronous active-low reset
//   sig_ni  in   active-low level input
//   fall_o  out  one-cycle pulse in the cycle the input is first seen low
// ----------------------------------------------------------------------------
module sc_edgedetect
    import sc_speedcomparator_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_ni,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_ni;
        end
    end

    assign fall_o = prev_q & ~sig_ni;

endmodule

// File: rtl/sc_speedcomparator.sv
// ----------------------------------------------------------------------------
// sc_speedcomparator
// Compares a free-running count against the threshold of the current speed
// level and emits a one-cycle tick plus a registered clear that resets the
// upstream counter. The speed level is stepped by falling edges on the
// active-low speedup/speeddown inputs and saturates at 0 and 3.
//
// Ports:
//   SC_SPEEDCOMPARATOR_CLOCK_50        in   system clock
//   SC_SPEEDCOMPARATOR_RESET_InLow     in   asynchronous active-low reset
//   SC_SPEEDCOMPARATOR_data_InBUS      in   count from speed counter
//   SC_SPEEDCOMPARATOR_speedup_InLow   in   falling edge -> one level up
//   SC_SPEEDCOMPARATOR_speeddown_InLow in   falling edge -> one level down
//   SC_SPEEDCOMPARATOR_T0_OutHigh      out  one-cycle tick per period
//   SC_SPEEDCOMPARATOR_clear_OutHigh   out  one-cycle counter clear
//   SC_SPEEDCOMPARATOR_level_OutBUS    out  current speed level
//
// state | meaning
// ------+-----------------------------------------------------------
// WAIT  | comparing count against threshold[level]
// TICK  | tick/clear high for one cycle, count ignored, back to WAIT
// ----------------------------------------------------------------------------
module sc_speedcomparator
    import sc_speedcomparator_pkg::*;
#(
    parameter int          SPEEDCOMPARATOR_DATAWIDTH = 28,
    parameter int unsigned SPEEDCOMPARATOR_LEVEL0    = SC_LEVEL0_DEFAULT,
    parameter int unsigned SPEEDCOMPARATOR_LEVEL1    = SC_LEVEL1_DEFAULT,
    parameter int unsigned SPEEDCOMPARATOR_LEVEL2    = SC_LEVEL2_DEFAULT,
    parameter int unsigned SPEEDCOMPARATOR_LEVEL3    = SC_LEVEL3_DEFAULT
) (
    input  logic                                 SC_SPEEDCOMPARATOR_CLOCK_50,
    input  logic                                 SC_SPEEDCOMPARATOR_RESET_InLow,
    input  logic [SPEEDCOMPARATOR_DATAWIDTH-1:0] SC_SPEEDCOMPARATOR_data_InBUS,
    input  logic                                 SC_SPEEDCOMPARATOR_speedup_InLow,
    input  logic                                 SC_SPEEDCOMPARATOR_speeddown_InLow,
    output logic                                 SC_SPEEDCOMPARATOR_T0_OutHigh,
    output logic                                 SC_SPEEDCOMPARATOR_clear_OutHigh,
    output logic [SC_LEVEL_W-1:0]                SC_SPEEDCOMPARATOR_level_OutBUS
);

    localparam int DW = SPEEDCOMPARATOR_DATAWIDTH;
    localparam logic [SC_LEVEL_W-1:0] LEVEL_MAX = 2'd3;
    localparam logic [SC_LEVEL_W-1:0] LEVEL_MIN = 2'd0;

    sc_state_e             state_q, state_d;
    logic [SC_LEVEL_W-1:0] level_q, level_d;
    logic                  t0_q, clear_q;
    logic                  up_fall, dn_fall;
    logic [DW-1:0]         thr_sel;

    sc_edgedetect u_edge_up (
        .clk_i  (SC_SPEEDCOMPARATOR_CLOCK_50),
        .rst_ni (SC_SPEEDCOMPARATOR_RESET_InLow),
        .sig_ni (SC_SPEEDCOMPARATOR_speedup_InLow),
        .fall_o (up_fall)
    );

    sc_edgedetect u_edge_dn (
        .clk_i  (SC_SPEEDCOMPARATOR_CLOCK_50),
        .rst_ni (SC_SPEEDCOMPARATOR_RESET_InLow),
        .sig_ni (SC_SPEEDCOMPARATOR_speeddown_InLow),
        .fall_o (dn_fall)
    );

    // Level register: simultaneous up/down edges cancel out.
    always_comb begin
        level_d = level_q;
        if (up_fall && !dn_fall && (level_q != LEVEL_MAX)) begin
            level_d = level_q + 2'd1;
        end else if (dn_fall && !up_fall && (level_q != LEVEL_MIN)) begin
            level_d = level_q - 2'd1;
        end
    end

    always_comb begin
        case (level_q)
            2'd0:    thr_sel = DW'(SPEEDCOMPARATOR_LEVEL0);
            2'd1:    thr_sel = DW'(SPEEDCOMPARATOR_LEVEL1);
            2'd2:    thr_sel = DW'(SPEEDCOMPARATOR_LEVEL2);
            default: thr_sel = DW'(SPEEDCOMPARATOR_LEVEL3);
        endcase
    end

    // ">=" so an overshoot, or a level change that drops the threshold
    // below the current count, still ticks on the next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SC_WAIT: begin
                if (SC_SPEEDCOMPARATOR_data_InBUS >= thr_sel) begin
                    state_d = SC_TICK;
                end
            end
            SC_TICK: state_d = SC_WAIT;
            default: state_d = SC_WAIT;
        endcase
    end

    always_ff @(posedge SC_SPEEDCOMPARATOR_CLOCK_50 or negedge SC_SPEEDCOMPARATOR_RESET_InLow) begin
        if (!SC_SPEEDCOMPARATOR_RESET_InLow) begin
            state_q <= SC_WAIT;
            level_q <= LEVEL_MIN;
            t0_q    <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            // Outputs come straight from flops loaded with the next state.
            t0_q    <= (state_d == SC_TICK);
            clear_q <= (state_d == SC_TICK);
        end
    end

    assign SC_SPEEDCOMPARATOR_T0_OutHigh    = t0_q;
    assign SC_SPEEDCOMPARATOR_clear_OutHigh = clear_q;
    assign SC_SPEEDCOMPARATOR_level_OutBUS  = level_q;

endmodule

// File: tb/tb_sc_speedcomparator.sv
// Directed bench for sc_speedcomparator with thresholds 10/6/4/2.
// Inputs are driven and outputs sampled on the falling clock edge.
// Cycle numbering: the cycle in which reset is released is cycle 1, so the
// n-th falling edge after release lies in cycle n+1.
module tb_sc_speedcomparator;
    localparam int DW = 28;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          up_n = 1'b1;
    logic          dn_n = 1'b1;
    logic          use_cnt = 1'b1;
    logic [DW-1:0] forced = '0;
    logic [DW-1:0] cnt;
    logic [DW-1:0] data;
    logic          t0, clr;
    logic [1:0]    level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Upstream speed counter model, reset by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else          cnt <= cnt + 1'b1;
    end

    assign data = use_cnt ? cnt : forced;

    sc_speedcomparator #(
        .SPEEDCOMPARATOR_DATAWIDTH (DW),
        .SPEEDCOMPARATOR_LEVEL0    (10),
        .SPEEDCOMPARATOR_LEVEL1    (6),
        .SPEEDCOMPARATOR_LEVEL2    (4),
        .SPEEDCOMPARATOR_LEVEL3    (2)
    ) dut (
        .SC_SPEEDCOMPARATOR_CLOCK_50        (clk),
        .SC_SPEEDCOMPARATOR_RESET_InLow     (rst_n),
        .SC_SPEEDCOMPARATOR_data_InBUS      (data),
        .SC_SPEEDCOMPARATOR_speedup_InLow   (up_n),
        .SC_SPEEDCOMPARATOR_speeddown_InLow (dn_n),
        .SC_SPEEDCOMPARATOR_T0_OutHigh      (t0),
        .SC_SPEEDCOMPARATOR_clear_OutHigh   (clr),
        .SC_SPEEDCOMPARATOR_level_OutBUS    (level)
    );

    // Number of falling edges until T0 is seen high; 0 if the bound expires.
    task automatic wait_t0(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (t0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press_up();
        up_n = 1'b0;
        @(negedge clk);
        up_n = 1'b1;
    endtask

    task automatic press_dn();
        dn_n = 1'b0;
        @(negedge clk);
        dn_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (t0 !== 1'b0 || clr !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: t0=%b clear=%b, required 0/0", t0, clr);
            end
        end
        n_tests++;
        if (level !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_level: level=%0d, required 0", level);
        end
    endtask

    // Release reset at a falling edge, then expect the first tick in cycle 12
    // (11th falling edge) and every 12 cycles after, clear coincident.
    task automatic test_period_level0();
        int n;
        rst_n = 1'b1;
        wait_t0(40, n);
        n_tests++;
        if (n != 11) begin
            n_fail++;
            $display("FAIL first_tick_l0: cycle=%0d, required 12", n + 1);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (clr !== 1'b1 || level !== 2'd0) begin
                n_fail++;
                $display("FAIL tick_clear_l0: clear=%b level=%0d, required 1/0", clr, level);
            end
            wait_t0(40, n);
            n_tests++;
            if (n != 12) begin
                n_fail++;
                $display("FAIL period_l0: period=%0d, required 12", n);
            end
        end
        @(negedge clk);
        n_tests++;
        if (t0 !== 1'b0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_width: t0=%b clear=%b, required 0/0", t0, clr);
        end
    endtask

    task automatic test_level_up_down();
        logic [1:0] exp_up [4];
        logic [1:0] exp_dn [4];
        int n;
        exp_up = '{2'd1, 2'd2, 2'd3, 2'd3};
        exp_dn = '{2'd2, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            press_up();
            n_tests++;
            if (level !== exp_up[i]) begin
                n_fail++;
                $display("FAIL level_up%0d: level=%0d, required %0d", i, level, exp_up[i]);
            end
            @(negedge clk);
        end
        wait_t0(40, n);
        wait_t0(40, n);
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL period_l3: period=%0d, required 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            press_dn();
            n_tests++;
            if (level !== exp_dn[i]) begin
                n_fail++;
                $display("FAIL level_dn%0d: level=%0d, required %0d", i, level, exp_dn[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous_and_hold();
        press_up();
        @(negedge clk);
        up_n = 1'b0;
        dn_n = 1'b0;
        @(negedge clk);
        up_n = 1'b1;
        dn_n = 1'b1;
        n_tests++;
        if (level !== 2'd1) begin
            n_fail++;
            $display("FAIL simultaneous: level=%0d, required 1", level);
        end
        @(negedge clk);
        up_n = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        n_tests++;
        if (level !== 2'd2) begin
            n_fail++;
            $display("FAIL held_low: level=%0d, required 2", level);
        end
        up_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (level !== 2'd2) begin
            n_fail++;
            $display("FAIL held_release: level=%0d, required 2", level);
        end
    endtask

    // Count held at 3 in level 2 (threshold 4): idle. Step to level 3
    // (threshold 2): tick one cycle after the level changes.
    task automatic test_level_change_latency();
        forced  = 28'd3;
        use_cnt = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (t0 !== 1'b0) begin
                n_fail++;
                $display("FAIL below_thr_l2: t0=%b, required 0", t0);
            end
        end
        up_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (level !== 2'd3 || t0 !== 1'b0) begin
            n_fail++;
            $display("FAIL lvl_change: level=%0d t0=%b, required 3/0", level, t0);
        end
        up_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (t0 !== 1'b1 || clr !== 1'b1) begin
            n_fail++;
            $display("FAIL lvl_change_tick: t0=%b clear=%b, required 1/1", t0, clr);
        end
    endtask

    task automatic test_direct_data();
        forced = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            press_dn();
            @(negedge clk);
        end
        n_tests++;
        if (level !== 2'd0) begin
            n_fail++;
            $display("FAIL direct_level: level=%0d, required 0", level);
        end
        forced = 28'd9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (t0 !== 1'b0) begin
                n_fail++;
                $display("FAIL below_thr_l0: t0=%b with data 9, required 0", t0);
            end
        end
        forced = 28'd10;
        @(negedge clk);
        n_tests++;
        if (t0 !== 1'b1) begin
            n_fail++;
            $display("FAIL equal_thr: t0=%b with data 10, required 1", t0);
        end
        forced = '0;
        @(negedge clk);
        @(negedge clk);
        forced = 28'hFFF_FFFF;
        @(negedge clk);
        n_tests++;
        if (t0 !== 1'b1 || clr !== 1'b1) begin
            n_fail++;
            $display("FAIL max_data: t0=%b clear=%b, required 1/1", t0, clr);
        end
        forced  = '0;
        use_cnt = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_tick();
        int n;
        press_up();
        wait_t0(40, n);
        n_tests++;
        if (n == 0) begin
            n_fail++;
            $display("FAIL pre_reset_tick: no tick within 40 cycles, required one");
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (t0 !== 1'b0 || clr !== 1'b0 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_tick: t0=%b clear=%b level=%0d, required 0/0/0", t0, clr, level);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        test_period_level0();
    endtask

    initial begin
        test_reset();
        test_period_level0();
        test_level_up_down();
        test_simultaneous_and_hold();
        test_level_change_latency();
        test_direct_data();
        test_reset_mid_tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
